// File: rtl/dual_ff_hs_tx.sv
// Purpose : transmit side of a 4-phase req/ack CDC handshake with per-phase timeout.
// Latency : accept -> tx_req next edge; ack_s rise -> tx_req low next edge; ack_s fall -> done next edge.
// Backpr. : send_ready low outside IDLE or while the synchronized ack is still high; no queuing.
//
// Ports:
//   d_clk        clock (sole clock of the block)
//   d_rst_n      asynchronous active-low reset
//   send_valid   local request to transfer send_data
//   send_data    word to transfer, captured when send_valid & send_ready
//   send_ready   block can accept a word this cycle (combinational)
//   tx_req       registered request level towards the far domain
//   tx_data      captured word, held stable through REQ and REL and afterwards
//   rx_ack       far-domain acknowledge, asynchronous to d_clk
//   done         one-cycle pulse on normal completion
//   timeout_err  sticky flag, set when a phase runs out of time
//   err_clr      synchronous clear of timeout_err (a simultaneous set wins)

module dual_ff_hs_tx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,   // must be >= 2
  parameter int TIMEOUT     = 16   // cycles per phase, 0 disables the timeout
) (
  input  logic              d_clk,
  input  logic              d_rst_n,
  input  logic              send_valid,
  input  logic [DATA_W-1:0] send_data,
  output logic              send_ready,
  output logic              tx_req,
  output logic [DATA_W-1:0] tx_data,
  input  logic              rx_ack,
  output logic              done,
  output logic              timeout_err,
  input  logic              err_clr
);

  // Counter is wide enough to hold TIMEOUT; one bit when the timeout is off.
  localparam int CNT_W     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int TO_LAST_I = (TIMEOUT < 1) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
  localparam bit   TO_EN   = (TIMEOUT != 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;

  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;

  logic [1:0]       state_q;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             req_nxt;
  logic             data_ld;
  logic             done_nxt;
  logic             to_fire;
  logic             cnt_expired;

  // ---------------------------------------------------------------------------
  // Ack synchronizer. rx_ack goes straight into the first flop; nothing else
  // looks at it, so the only metastability exposure is inside this chain.
  // ---------------------------------------------------------------------------
  always_ff @(posedge d_clk or negedge d_rst_n) begin
    if (!d_rst_n) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], rx_ack};
    end
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];

  // A stale ack from the previous transfer (or a spurious one) must be gone
  // before a new request is raised, otherwise REQ would complete instantly.
  assign send_ready = (state_q == ST_IDLE) && !ack_s;

  // The phase budget is spent when the counter reaches its last value while
  // the awaited ack edge still has not arrived.
  assign cnt_expired = TO_EN && (cnt_q == TO_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state_q;
    req_nxt   = tx_req;
    data_ld   = 1'b0;
    done_nxt  = 1'b0;
    to_fire   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A valid that is not ready is dropped, not remembered.
        if (send_valid && send_ready) begin
          state_nxt = ST_REQ;
          req_nxt   = 1'b1;
          data_ld   = 1'b1;
        end
      end

      ST_REQ: begin
        if (ack_s) begin
          state_nxt = ST_REL;
          req_nxt   = 1'b0;
        end else if (cnt_expired) begin
          // Abort: drop the request without ever having seen the ack.
          state_nxt = ST_IDLE;
          req_nxt   = 1'b0;
          to_fire   = 1'b1;
        end
      end

      ST_REL: begin
        if (!ack_s) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else if (cnt_expired) begin
          // Ack stuck high; send_ready stays low in IDLE until it clears.
          state_nxt = ST_IDLE;
          to_fire   = 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  // Phase counter: restarts on every state change, runs only inside a phase.
  always_comb begin
    cnt_nxt = '0;
    if (state_nxt == state_q && state_q != ST_IDLE && TO_EN) begin
      cnt_nxt = cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge d_clk or negedge d_rst_n) begin
    if (!d_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tx_req  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      tx_req  <= req_nxt;
      done    <= done_nxt;
    end
  end

  // tx_data only moves on accept, so the far side can sample it any time
  // during the handshake and it remains readable after completion.
  always_ff @(posedge d_clk or negedge d_rst_n) begin
    if (!d_rst_n) begin
      tx_data <= '0;
    end else if (data_ld) begin
      tx_data <= send_data;
    end
  end

  // Sticky error: a new timeout beats a clear in the same cycle so that no
  // error event can be lost.
  always_ff @(posedge d_clk or negedge d_rst_n) begin
    if (!d_rst_n) begin
      timeout_err <= 1'b0;
    end else if (to_fire) begin
      timeout_err <= 1'b1;
    end else if (err_clr) begin
      timeout_err <= 1'b0;
    end
  end

endmodule
